dec_latch_n: RTL
================

Name: dec_latch_n

Overview:
- Parametrised successor to the dual 2-to-4 decoder family used for board address decoding.
- Provides CHANNELS independent SEL_W-to-2^SEL_W active-low decoders.
- Each channel adds a per-channel address latch (74LS137-style) and a selectable one-shot strobe mode, so chip-select and write-strobe pulses can be generated synchronously from the system clock.
- Outputs are registered.

Parameters:
- CHANNELS, 2, number of independent decoder channels (>=1).
- SEL_W, 2, select width per channel; each channel drives 2**SEL_W outputs (1..4).
- PULSE_LEN, 4, pulse-mode output width in clocks (>=1); counter width is $clog2(PULSE_LEN+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- g_n  in  CHANNELS  per-channel enable, active-low.
- le_n  in  CHANNELS  per-channel address latch enable, active-low; low = transparent, high = hold.
- sel  in  CHANNELS*SEL_W  per-channel select; channel c occupies bits [c*SEL_W +: SEL_W].
- mode  in  CHANNELS  per-channel mode: 0 = level decode, 1 = one-shot pulse.
- y_n  out  CHANNELS*2**SEL_W  decoded outputs, active-low; channel c line k is bit c*2**SEL_W + k.
- busy  out  CHANNELS  high while that channel's pulse is active.

Behaviour:
- Reset (rst=1 at a clock edge):
  - y_n all 1s, busy all 0s.
  - Address latches cleared to 0, pulse counters cleared to 0.
  - Enable history register g_q set to all 1s.
  - rst has priority over every other input.
- Channels are fully independent; no shared state.
- Effective address per channel: eff = sel when le_n=0, otherwise the latched address. The latch loads sel on every clock with le_n=0 and holds while le_n=1.
- Level mode (mode=0):
  - At each edge, channel line k drives 0 if g_n=0 and eff==k, otherwise 1.
  - Latency is 1 clock from input to y_n. busy=0.
- Pulse mode (mode=1):
  - State IDLE (count=0): a trigger is g_q=1 and g_n=0 (falling enable edge). On a trigger, eff is captured into the pulse address and count loads PULSE_LEN.
  - State ACTIVE (count>0): y_n line [pulse address] is 0 and all other lines are 1. count decrements each clock. busy=1.
  - Pulse timing: low for exactly PULSE_LEN clocks, starting the clock after the trigger edge.
  - Triggers during ACTIVE are ignored (non-retriggerable). Changes to sel/le_n/g_n during ACTIVE do not alter the pulse address or truncate the pulse.
  - When count reaches 0, y_n returns to all 1s and busy=0 on the same edge.
  - A falling edge on the exact cycle count reaches 0 is accepted. The pulse then restarts with no gap, provided g_q=1 on that cycle.
- g_q <= g_n every clock, in both modes.
  - g_n held low out of reset therefore triggers once on the first post-reset cycle in pulse mode.
- Mode change:
  - 1 -> 0 while ACTIVE aborts the pulse: count cleared, busy=0, and level decoding applies from the next edge.
  - 0 -> 1 with g_n already low does not trigger; a new falling edge is required.

Test Plan:
- Level sweep:
  - Stimulus: CHANNELS=2, SEL_W=2, ch0 mode=0, le_n=0, g_n=0, sel 0,1,2,3 on consecutive clocks.
  - Required: ch0 y_n[3:0] = 1110, 1101, 1011, 0111, each one clock later.
  - Then g_n=1 -> 1111.
- Latch hold:
  - Stimulus: ch0 le_n=0 with sel=2 for one clock, then le_n=1 with sel=1.
  - Required: y_n[3:0] stays 1011.
  - Then le_n=0 -> 1101 on the next clock.
- One-shot:
  - Stimulus: PULSE_LEN=4, ch0 mode=1, sel=3, g_n 1 -> 0 sampled at edge T.
  - Required: y_n[3:0]=0111 and busy[0]=1 for edges T+1..T+4; 1111 and busy=0 at T+5.
- Non-retrigger:
  - Stimulus: during that pulse, g_n pulsed high then low at T+2 with sel=0.
  - Required: no change; the pulse still ends at T+5 on line 3.
- Reset mid-pulse:
  - Stimulus: rst=1 at T+2.
  - Required: at T+3, y_n=all 1s and busy=0.
  - Then, with rst released and g_n held low, the pulse fires again on the first clock after release.
- Channel independence:
  - Stimulus: ch1 mode=0, g_n=0, sel=1, while ch0 pulses line 3.
  - Required: y_n[7:4]=1101 throughout, and ch0 timing is unchanged.

Source files
------------

// File: rtl/dec_latch_n.sv
// Multi-channel active-low address decoder with per-channel address latch and
// an optional non-retriggerable one-shot strobe mode. All outputs are registered.
module dec_latch_n #(
  parameter int CHANNELS  = 2,
  parameter int SEL_W     = 2,
  parameter int PULSE_LEN = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             g_n,
  input  logic [CHANNELS-1:0]             le_n,
  input  logic [CHANNELS*SEL_W-1:0]       sel,
  input  logic [CHANNELS-1:0]             mode,
  output logic [CHANNELS*(2**SEL_W)-1:0]  y_n,
  output logic [CHANNELS-1:0]             busy
);

  localparam int NL = 2 ** SEL_W;
  localparam int CW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  function automatic logic [NL-1:0] dec_n(input logic [SEL_W-1:0] a);
    logic [NL-1:0] v;
    v    = {NL{1'b1}};
    v[a] = 1'b0;
    return v;
  endfunction

  logic [CHANNELS-1:0][SEL_W-1:0] addr_q, addr_d;
  logic [CHANNELS-1:0][SEL_W-1:0] paddr_q, paddr_d;
  logic [CHANNELS-1:0][SEL_W-1:0] eff_s;
  logic [CHANNELS-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0]            g_q, g_d;
  logic [CHANNELS-1:0]            busy_q, busy_d;
  logic [CHANNELS*NL-1:0]         y_n_q, y_n_d;

  // Next-state: address latch, enable history, pulse counter and decoded outputs.
  always_comb begin
    eff_s   = {(CHANNELS*SEL_W){1'b0}};
    addr_d  = addr_q;
    paddr_d = paddr_q;
    cnt_d   = cnt_q;
    g_d     = g_n;
    busy_d  = {CHANNELS{1'b0}};
    y_n_d   = {(CHANNELS*NL){1'b1}};
    for (int c = 0; c < CHANNELS; c++) begin
      if (le_n[c]) begin
        eff_s[c] = addr_q[c];
      end else begin
        eff_s[c] = sel[c*SEL_W +: SEL_W];
      end
      addr_d[c] = eff_s[c];
      if (mode[c]) begin
        // count_q==1 is the last low cycle, so a trigger there restarts with no gap
        if (cnt_q[c] > CNT_ONE) begin
          cnt_d[c]              = cnt_q[c] - CNT_ONE;
          busy_d[c]             = 1'b1;
          y_n_d[c*NL +: NL]     = dec_n(paddr_q[c]);
        end else if (g_q[c] && !g_n[c]) begin
          cnt_d[c]              = CNT_LOAD;
          paddr_d[c]            = eff_s[c];
          busy_d[c]             = 1'b1;
          y_n_d[c*NL +: NL]     = dec_n(eff_s[c]);
        end else begin
          cnt_d[c]              = CNT_ZERO;
          busy_d[c]             = 1'b0;
          y_n_d[c*NL +: NL]     = {NL{1'b1}};
        end
      end else begin
        cnt_d[c]  = CNT_ZERO;
        busy_d[c] = 1'b0;
        if (!g_n[c]) begin
          y_n_d[c*NL +: NL] = dec_n(eff_s[c]);
        end else begin
          y_n_d[c*NL +: NL] = {NL{1'b1}};
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= {(CHANNELS*SEL_W){1'b0}};
      paddr_q <= {(CHANNELS*SEL_W){1'b0}};
      cnt_q   <= {(CHANNELS*CW){1'b0}};
      g_q     <= {CHANNELS{1'b1}};
      busy_q  <= {CHANNELS{1'b0}};
      y_n_q   <= {(CHANNELS*NL){1'b1}};
    end else begin
      addr_q  <= addr_d;
      paddr_q <= paddr_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      busy_q  <= busy_d;
      y_n_q   <= y_n_d;
    end
  end

  assign y_n  = y_n_q;
  assign busy = busy_q;

endmodule
